bp_io_mem_responder: RTL and testbench
======================================

Name: bp_io_mem_responder

Overview:
- IO-side target for the uncached memory-message interface: accepts uc_rd / uc_wr commands from an IO CCE and returns one response per command.
- Backed by a small byte-addressable register file. Models a configurable fixed access latency.
- Used as a bench/SoC stub device on the io_cmd / io_resp link.
- Single outstanding command; a response is held until the consumer accepts it.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p and cce_mem_msg_width_lp.
- els_p, 16, number of 64-bit words in the register file; must be a power of two, at least 2.
- latency_p, 2, cycles from command acceptance to response valid; 0 to 255.
- base_addr_p, paddr_width_p'h0010_0000, byte base address of the device; aligned to els_p*8.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- io_cmd_i  in  cce_mem_msg_width_lp  command message (header + data).
- io_cmd_v_i  in  1  command valid.
- io_cmd_yumi_o  out  1  command consumed this cycle.
- io_resp_o  out  cce_mem_msg_width_lp  response message.
- io_resp_v_o  out  1  response valid.
- io_resp_ready_i  in  1  consumer can accept response.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low (reset_n_i).
- While reset_n_i is low:
  - state = READY; io_resp_v_o = 0; io_resp_o = 0; io_cmd_yumi_o = 0.
  - Latched header/data cleared; latency counter = 0.
  - All register-file words = 0.
- Reset asserted mid-operation drops any pending command or response. No response is produced for it after reset release.
- FSM states: READY, WAIT, RESP.
  - READY: io_cmd_yumi_o = io_cmd_v_i (combinational). On yumi, latch the header and compute the response.
    - latency_p = 0: next state RESP.
    - Otherwise: counter <= latency_p-1; next state WAIT.
  - WAIT: counter decrements each cycle; when counter = 0, next state RESP. io_cmd_yumi_o = 0.
  - RESP: io_resp_v_o = 1; io_resp_o held stable. On io_resp_ready_i, next state READY. No command is accepted in the handshake cycle.
- Latency and throughput:
  - Response valid latency_p+1 cycles after the acceptance edge.
  - Minimum command spacing is latency_p+2 cycles.
- Address decode:
  - offset = addr - base_addr_p.
  - In-range iff 0 <= offset < els_p*8.
  - Word index = offset[3 +: log2(els_p)]; byte offset b = offset[2:0].
- Size: header.size gives the byte count n = 1, 2, 4 or 8. Sizes above 8 bytes are treated as 8.
- Alignment: effective byte offset = b & ~(n-1). Low address bits are ignored; misalignment never faults.
- uc_wr, in range:
  - Bytes [eb, eb+n) of the word are written from data[8n-1:0].
  - Write commits at the acceptance edge. Other bytes of the word are unchanged.
- uc_rd, in range: response data = (word >> 8*eb) masked to 8n bits, zero-extended to cce_block_width_p. The word is read at the acceptance edge.
- Out-of-range: writes are dropped; reads return data 0. A response is still produced.
- Any other msg_type: no register-file access; data 0; response still produced.
- Response header: msg_type, addr, size and the whole payload (lce_id, way, uncached, ...) are copied unchanged from the command. Write responses carry data 0.
- A read following a write to the same word sees the written value (commands are serialised).

Test Plan:
1. Reset, then uc_wr addr 0x10_0008, size 8, data 0x1122_3344_5566_7788; latency_p=2.
   -> yumi in the same cycle as valid.
   -> io_resp_v_o rises 3 cycles later; msg_type uc_wr, data 0, addr and lce_id echoed.
2. uc_rd addr 0x10_000A, size 2 after test 1 -> response data 0x5566. uc_rd addr 0x10_000B, size 2 -> also 0x5566 (aligned down).
3. uc_wr addr 0x10_000C, size 1, data 0xAB; then uc_rd addr 0x10_0008, size 8 -> 0x1122_33AB_5566_7788.
4. Backpressure: hold io_resp_ready_i low 5 cycles with io_cmd_v_i high.
   -> io_resp_o stable throughout; io_cmd_yumi_o stays 0.
   -> After the handshake, next yumi no earlier than the following cycle.
5. Out of range: uc_wr then uc_rd at addr 0x10_0080 (els_p=16).
   -> Both respond; read data 0; no register-file word changes.
6. Pull reset_n_i low during WAIT.
   -> io_resp_v_o never asserts for that command; all outputs 0 immediately.
   -> A subsequent read of 0x10_0008 returns 0.

Source files
------------

// File: rtl/bp_io_mem_responder.sv
// IO-side uncached memory target: serves uc_rd / uc_wr from a small register file
// after a fixed latency. Message = {data[cce_block_width_p], payload, size[3], addr, msg_type[4]}.
module bp_io_mem_responder
  #(parameter int paddr_width_p     = 40
  , parameter int cce_block_width_p = 512
  , parameter int lce_id_width_p    = 4
  , parameter int lce_assoc_p       = 8
  , parameter int els_p             = 16
  , parameter int latency_p         = 2
  , parameter logic [paddr_width_p-1:0] base_addr_p = paddr_width_p'('h0010_0000)
  , localparam int way_width_lp         = $clog2(lce_assoc_p)
  , localparam int payload_width_lp     = lce_id_width_p + way_width_lp + 1
  , localparam int hdr_width_lp         = 4 + paddr_width_p + 3 + payload_width_lp
  , localparam int cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p
  )
  (input  logic                            clk_i
  , input  logic                            reset_n_i
  , input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i
  , input  logic                            io_cmd_v_i
  , output logic                            io_cmd_yumi_o
  , output logic [cce_mem_msg_width_lp-1:0] io_resp_o
  , output logic                            io_resp_v_o
  , input  logic                            io_resp_ready_i
  );

  localparam int idx_width_lp = $clog2(els_p);
  localparam int size_lsb_lp  = 4 + paddr_width_p;
  localparam logic [3:0] uc_rd_c = 4'd2;
  localparam logic [3:0] uc_wr_c = 4'd3;

  typedef enum logic [1:0] {e_ready, e_wait, e_resp} state_e;

  state_e                    state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [hdr_width_lp-1:0]   hdr_q, hdr_d;
  logic [63:0]               rdata_q, rdata_d;
  logic [63:0]               mem_q [els_p];

  logic [3:0]                cmd_type;
  logic [paddr_width_p-1:0]  cmd_addr, offset;
  logic [2:0]                cmd_size, eb;
  logic [63:0]               cmd_data, fmask, wmask, wdata, rd_val;
  logic [1:0]                n_log;
  logic [5:0]                shift_amt;
  logic [idx_width_lp-1:0]   idx;
  logic                      in_range, accept, wr_en;
  logic                      unused_data;

  assign cmd_type    = io_cmd_i[3:0];
  assign cmd_addr    = io_cmd_i[4 +: paddr_width_p];
  assign cmd_size    = io_cmd_i[size_lsb_lp +: 3];
  assign cmd_data    = io_cmd_i[hdr_width_lp +: 64];
  assign unused_data = ^io_cmd_i[cce_mem_msg_width_lp-1:hdr_width_lp+64];

  // Below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds.
  assign offset    = cmd_addr - base_addr_p;
  assign in_range  = offset < paddr_width_p'(els_p * 8);
  assign idx       = offset[3 +: idx_width_lp];
  assign n_log     = (cmd_size > 3'd3) ? 2'd3 : cmd_size[1:0];
  assign eb        = offset[2:0] & ~((3'd1 << n_log) - 3'd1);
  assign shift_amt = {eb, 3'b000};

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    fmask = '1;
    case (n_log)
      2'd0:    fmask = 64'h0000_0000_0000_00ff;
      2'd1:    fmask = 64'h0000_0000_0000_ffff;
      2'd2:    fmask = 64'h0000_0000_ffff_ffff;
      default: fmask = '1;
    endcase
  end

  assign wmask  = fmask << shift_amt;
  assign wdata  = (cmd_data & fmask) << shift_amt;
  assign rd_val = (mem_q[idx] >> shift_amt) & fmask;

  assign accept = reset_n_i && (state_q == e_ready) && io_cmd_v_i;
  assign wr_en  = accept && (cmd_type == uc_wr_c) && in_range;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (!reset_n_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
      hdr_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the register file is reset word by word, which keeps it in flops rather than RAM.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= (mem_q[idx] & ~wmask) | wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_ready: if (accept) state_d = (latency_p == 0) ? e_resp : e_wait;
      e_wait:  if (cnt_q == '0) state_d = e_resp;
      e_resp:  if (io_resp_ready_i) state_d = e_ready;
      default: state_d = e_ready;
    endcase
  end

  // Latched response and latency counter; the read happens against pre-write contents.
  always_comb begin
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d   = (latency_p == 0) ? 8'd0 : 8'(latency_p - 1);
      hdr_d   = io_cmd_i[hdr_width_lp-1:0];
      rdata_d = ((cmd_type == uc_rd_c) && in_range) ? rd_val : 64'd0;
    end else if ((state_q == e_wait) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Output logic
  always_comb begin
    io_cmd_yumi_o = accept;
    io_resp_v_o   = (state_q == e_resp);
    io_resp_o     = {cce_block_width_p'(rdata_q), hdr_q};
  end

endmodule

// File: tb/tb_bp_io_mem_responder.sv
// Self-checking bench for bp_io_mem_responder: byte-level reference model plus
// a response scoreboard, with latency, backpressure, range and reset checks.
module tb_bp_io_mem_responder;

  localparam int LAT   = 2;
  localparam int ELS   = 16;
  localparam int HDR_W = 55;
  localparam int BLK_W = 512;
  localparam int MSG_W = HDR_W + BLK_W;
  localparam logic [39:0] BASE  = 40'h10_0000;
  localparam logic [3:0]  UC_RD = 4'd2;
  localparam logic [3:0]  UC_WR = 4'd3;
  localparam logic [3:0]  OTHER = 4'd0;

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic [MSG_W-1:0] io_cmd_i;
  logic             io_cmd_v_i;
  logic             io_cmd_yumi_o;
  logic [MSG_W-1:0] io_resp_o;
  logic             io_resp_v_o;
  logic             io_resp_ready_i;

  typedef struct {
    logic [3:0]  t;
    logic [39:0] a;
    logic [2:0]  sz;
    logic [7:0]  pl;
    logic [63:0] d;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [ELS*8];
  int         n_checks = 0;
  int         n_errors = 0;

  bp_io_mem_responder #(
    .paddr_width_p(40), .cce_block_width_p(BLK_W), .lce_id_width_p(4), .lce_assoc_p(8),
    .els_p(ELS), .latency_p(LAT), .base_addr_p(BASE)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_yumi_o(io_cmd_yumi_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [39:0] a, input logic [2:0] sz);
    logic [39:0] off;
    logic [63:0] v;
    int n, b, eb, base;
    off = a - BASE;
    v = '0;
    if (off >= 40'(ELS * 8)) return '0;
    n = (sz > 3'd3) ? 8 : (1 << sz);
    b = int'(off % 40'd8);
    eb = b - (b % n);
    base = int'(off / 40'd8) * 8;
    for (int i = 0; i < n; i++) v = v | (64'(model[base + eb + i]) << (8 * i));
    return v;
  endfunction

  task automatic model_wr(input logic [39:0] a, input logic [2:0] sz, input logic [63:0] d);
    logic [39:0] off;
    int n, b, eb, base;
    off = a - BASE;
    if (off < 40'(ELS * 8)) begin
      n = (sz > 3'd3) ? 8 : (1 << sz);
      b = int'(off % 40'd8);
      eb = b - (b % n);
      base = int'(off / 40'd8) * 8;
      for (int i = 0; i < n; i++) model[base + eb + i] = d[8*i +: 8];
    end
  endtask

  function automatic logic [MSG_W-1:0] build_cmd(input logic [3:0] t, input logic [39:0] a,
                                                 input logic [2:0] sz, input logic [7:0] pl,
                                                 input logic [63:0] d);
    logic [MSG_W-1:0] m;
    m = '0;
    m[3:0]           = t;
    m[4 +: 40]       = a;
    m[44 +: 3]       = sz;
    m[47 +: 8]       = pl;
    m[HDR_W +: 64]   = d;
    m[HDR_W+64 +: 64] = 64'hC0FF_EE00_DEAD_BEEF;
    return m;
  endfunction

  // Scoreboard consumer: compares every accepted response against the oldest expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (reset_n_i && io_resp_v_o && io_resp_ready_i) begin
      if (sb.size() == 0) begin
        check("spurious_resp", 64'(io_resp_v_o), 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_type",    64'(io_resp_o[3:0]),   64'(e.t));
        check("resp_addr",    64'(io_resp_o[4 +: 40]), 64'(e.a));
        check("resp_size",    64'(io_resp_o[44 +: 3]), 64'(e.sz));
        check("resp_payload", 64'(io_resp_o[47 +: 8]), 64'(e.pl));
        check("resp_data",    io_resp_o[HDR_W +: 64], e.d);
        check("resp_data_hi_zero", 64'(io_resp_o[MSG_W-1:HDR_W+64] == '0), 64'd1);
      end
    end
  end

  // Issue one command and follow it to its handshake; entered and left just after a posedge.
  task automatic send(input logic [3:0] t, input logic [39:0] a, input logic [2:0] sz,
                      input logic [7:0] pl, input logic [63:0] d, input int stall);
    exp_t e;
    int cyc;
    logic [MSG_W-1:0] snap;
    io_cmd_i = build_cmd(t, a, sz, pl, d);
    io_cmd_v_i = 1'b1;
    io_resp_ready_i = (stall == 0);
    @(negedge clk_i);
    check("yumi_same_cycle", 64'(io_cmd_yumi_o), 64'd1);
    cyc = 0;
    while (!io_cmd_yumi_o && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!io_cmd_yumi_o) begin
      check("yumi_timeout", 64'(io_cmd_yumi_o), 64'd1);
      io_cmd_v_i = 1'b0;
      @(posedge clk_i); #1;
      return;
    end
    e.t = t; e.a = a; e.sz = sz; e.pl = pl;
    e.d = (t == UC_RD) ? model_rd(a, sz) : 64'd0;
    if (t == UC_WR) model_wr(a, sz, d);
    sb.push_back(e);
    @(posedge clk_i); #1;
    io_cmd_v_i = (stall > 0);
    cyc = 1;
    @(negedge clk_i);
    while (!io_resp_v_o && cyc < 300) begin
      cyc++;
      @(negedge clk_i);
    end
    check("resp_latency", 64'(cyc), 64'(LAT + 1));
    if (!io_resp_v_o) begin
      sb.delete();
      io_cmd_v_i = 1'b0;
      @(posedge clk_i); #1;
      return;
    end
    if (stall > 0) begin
      snap = io_resp_o;
      for (int i = 0; i < stall; i++) begin
        check("bp_hold_valid",  64'(io_resp_v_o), 64'd1);
        check("bp_resp_stable", 64'(io_resp_o == snap), 64'd1);
        check("bp_no_yumi",     64'(io_cmd_yumi_o), 64'd0);
        if (i == stall - 1) begin
          @(posedge clk_i); #1;
          io_resp_ready_i = 1'b1;
        end
        @(negedge clk_i);
      end
      check("hs_no_yumi", 64'(io_cmd_yumi_o), 64'd0);
      check("hs_resp_stable", 64'(io_resp_o == snap), 64'd1);
    end
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < ELS*8; i++) model[i] = 8'h00;
    reset_n_i = 1'b0;
    io_cmd_i = build_cmd(UC_WR, BASE, 3'd3, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    io_cmd_v_i = 1'b1;
    io_resp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_resp_v",    64'(io_resp_v_o), 64'd0);
    check("rst_yumi",      64'(io_cmd_yumi_o), 64'd0);
    check("rst_resp_zero", 64'(io_resp_o == '0), 64'd1);
    reset_n_i = 1'b1;
    io_cmd_v_i = 1'b0;
    @(posedge clk_i); #1;

    // Write, sub-word reads (including misaligned), byte merge, full-word readback.
    send(UC_WR, 40'h10_0008, 3'd3, 8'h5A, 64'h1122_3344_5566_7788, 0);
    send(UC_RD, 40'h10_000A, 3'd1, 8'h21, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    send(UC_RD, 40'h10_000B, 3'd1, 8'h33, 64'h0, 0);
    send(UC_WR, 40'h10_000C, 3'd0, 8'h45, 64'h0000_0000_0000_00AB, 0);
    send(UC_RD, 40'h10_0008, 3'd3, 8'h9C, 64'h0, 0);

    // Backpressure with a competing command held valid.
    send(UC_RD, 40'h10_0008, 3'd3, 8'hE7, 64'h0, 5);

    // Out-of-range both above and below the window.
    send(UC_WR, 40'h10_0080, 3'd3, 8'h11, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    send(UC_RD, 40'h10_0080, 3'd3, 8'h12, 64'h0, 0);
    send(UC_WR, 40'h0F_FFF8, 3'd3, 8'h13, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    // Misaligned 4-byte write, oversize read, top word, and a non-uc message type.
    send(UC_WR, 40'h10_0013, 3'd2, 8'h77, 64'hCAFE_BABE_1234_5678, 0);
    send(UC_RD, 40'h10_0010, 3'd3, 8'h78, 64'h0, 0);
    send(UC_RD, 40'h10_0016, 3'd5, 8'h79, 64'h0, 0);
    send(UC_WR, 40'h10_0078, 3'd3, 8'h7A, 64'h0102_0304_0506_0708, 0);
    send(UC_RD, 40'h10_007D, 3'd0, 8'h7B, 64'h0, 0);
    send(OTHER, 40'h10_0010, 3'd3, 8'h7C, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    // Full sweep confirms no stray writes.
    for (int w = 0; w < ELS; w++)
      send(UC_RD, BASE + 40'(8 * w), 3'd3, 8'(w), 64'h0, 0);

    // Reset while the command is waiting out its latency.
    io_cmd_i = build_cmd(UC_WR, 40'h10_0018, 3'd3, 8'h66, 64'hDEAD_DEAD_DEAD_DEAD);
    io_cmd_v_i = 1'b1;
    io_resp_ready_i = 1'b1;
    @(negedge clk_i);
    check("rst_test_yumi", 64'(io_cmd_yumi_o), 64'd1);
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;
    @(negedge clk_i);
    check("rst_test_waiting", 64'(io_resp_v_o), 64'd0);
    reset_n_i = 1'b0;
    io_cmd_v_i = 1'b1;
    #1;
    check("midrst_resp_v",    64'(io_resp_v_o), 64'd0);
    check("midrst_yumi",      64'(io_cmd_yumi_o), 64'd0);
    check("midrst_resp_zero", 64'(io_resp_o == '0), 64'd1);
    sb.delete();
    for (int i = 0; i < ELS*8; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    io_cmd_v_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("no_resp_after_rst", 64'(io_resp_v_o), 64'd0);
    end
    @(posedge clk_i); #1;
    send(UC_RD, 40'h10_0008, 3'd3, 8'h01, 64'h0, 0);
    send(UC_RD, 40'h10_0018, 3'd3, 8'h02, 64'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
